// File: rtl/pong_sound_ctrl.sv
// Pong sound scheduler: arbitrates wall/paddle/score requests onto one square-wave tone generator.
// Optional build macro SOUND_PREEMPT_EN lets a higher-priority request cut the current sound short.
module pong_sound_ctrl #(
   parameter int unsigned TICK_DIV    = 100_000,
   parameter int unsigned WALL_HALF   = 200_000,
   parameter int unsigned PADDLE_HALF = 100_000,
   parameter int unsigned SCORE_HALF  = 50_000,
   parameter int unsigned WALL_MS     = 30,
   parameter int unsigned PADDLE_MS   = 50,
   parameter int unsigned SCORE_MS    = 300,
   parameter int unsigned GAP_MS      = 10
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       i_enable,
   input  logic       i_wall_hit,
   input  logic       i_paddle_hit,
   input  logic       i_score,
   output logic       o_tone,
   output logic       o_busy,
   output logic [1:0] o_sound_id
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned MAX_HALF = max2(WALL_HALF, max2(PADDLE_HALF, SCORE_HALF));
   localparam int unsigned MAX_MS   = max2(max2(WALL_MS, GAP_MS), max2(PADDLE_MS, SCORE_MS));
   localparam int HALF_W = $clog2(MAX_HALF + 1);
   localparam int TICK_W = $clog2(MAX_MS + 1);
   localparam int PRE_W  = $clog2(TICK_DIV + 1);

   localparam logic [HALF_W-1:0] WALL_HALF_M1   = HALF_W'(WALL_HALF - 1);
   localparam logic [HALF_W-1:0] PADDLE_HALF_M1 = HALF_W'(PADDLE_HALF - 1);
   localparam logic [HALF_W-1:0] SCORE_HALF_M1  = HALF_W'(SCORE_HALF - 1);
   localparam logic [HALF_W-1:0] HALF_ONE       = HALF_W'(1);
   localparam logic [TICK_W-1:0] WALL_MS_M1     = TICK_W'(WALL_MS - 1);
   localparam logic [TICK_W-1:0] PADDLE_MS_M1   = TICK_W'(PADDLE_MS - 1);
   localparam logic [TICK_W-1:0] SCORE_MS_M1    = TICK_W'(SCORE_MS - 1);
   localparam logic [TICK_W-1:0] GAP_MS_M1      = TICK_W'(GAP_MS - 1);
   localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(1);
   localparam logic [PRE_W-1:0]  TICK_DIV_M1    = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0]  PRE_ONE        = PRE_W'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [2:0]        pend_q, pend_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic [HALF_W-1:0] tone_cnt_q, tone_cnt_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [TICK_W-1:0] dur_q, dur_d;
   logic              tone_q, tone_d;
   logic              busy_q, busy_d;
   logic [1:0]        id_q, id_d;

   logic [2:0] req;
   logic [2:0] pend_clr;
   logic [1:0] top_id;
   logic       preempt;
   logic       do_grant;
   logic       pre_wrap;
   logic       phase_end;

   // Pending bit index + 1 equals the sound id, so the highest set bit is also the priority winner.
   assign req    = {i_score, i_paddle_hit, i_wall_hit};
   assign top_id = pend_q[2] ? 2'd3 : (pend_q[1] ? 2'd2 : (pend_q[0] ? 2'd1 : 2'd0));

`ifdef SOUND_PREEMPT_EN
   assign preempt = (top_id > id_q);
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      dur_d      = dur_q;
      tone_cnt_d = tone_cnt_q;
      pre_d      = pre_q;
      tick_d     = tick_q;
      tone_d     = tone_q;
      id_d       = id_q;
      pend_clr   = 3'b000;
      do_grant   = 1'b0;
      pre_wrap   = (pre_q == TICK_DIV_M1);
      phase_end  = pre_wrap && (tick_q == dur_q);

      case (state_q)
         ST_IDLE: do_grant = (top_id != 2'd0);
         ST_PLAY: begin
            if (preempt) begin
               do_grant = 1'b1;
            end else begin
               if (tone_cnt_q == half_q) begin
                  tone_cnt_d = '0;
                  tone_d     = ~tone_q;
               end else begin
                  tone_cnt_d = tone_cnt_q + HALF_ONE;
               end
               pre_d  = pre_wrap ? '0 : pre_q + PRE_ONE;
               tick_d = pre_wrap ? tick_q + TICK_ONE : tick_q;
               // The gap reuses the prescaler and tick counter with its own duration.
               if (phase_end) begin
                  state_d    = ST_GAP;
                  tone_d     = 1'b0;
                  tone_cnt_d = '0;
                  id_d       = 2'd0;
                  tick_d     = '0;
                  dur_d      = GAP_MS_M1;
               end
            end
         end
         ST_GAP: begin
            pre_d  = pre_wrap ? '0 : pre_q + PRE_ONE;
            tick_d = pre_wrap ? tick_q + TICK_ONE : tick_q;
            if (phase_end) begin
               state_d = ST_IDLE;
               tick_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_grant) begin
         state_d    = ST_PLAY;
         id_d       = top_id;
         tone_d     = 1'b0;
         tone_cnt_d = '0;
         pre_d      = '0;
         tick_d     = '0;
         case (top_id)
            2'd3: begin half_d = SCORE_HALF_M1;  dur_d = SCORE_MS_M1;  pend_clr = 3'b100; end
            2'd2: begin half_d = PADDLE_HALF_M1; dur_d = PADDLE_MS_M1; pend_clr = 3'b010; end
            default: begin half_d = WALL_HALF_M1; dur_d = WALL_MS_M1; pend_clr = 3'b001; end
         endcase
      end

      // Disabling mutes and flushes everything regardless of state.
      if (!i_enable) begin
         state_d    = ST_IDLE;
         tone_d     = 1'b0;
         id_d       = 2'd0;
         tone_cnt_d = '0;
         pre_d      = '0;
         tick_d     = '0;
      end

      pend_d = i_enable ? ((pend_q & ~pend_clr) | req) : 3'b000;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         half_q     <= '0;
         dur_q      <= '0;
         tone_cnt_q <= '0;
         pre_q      <= '0;
         tick_q     <= '0;
         tone_q     <= 1'b0;
         busy_q     <= 1'b0;
         id_q       <= 2'd0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         half_q     <= half_d;
         dur_q      <= dur_d;
         tone_cnt_q <= tone_cnt_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
         tone_q     <= tone_d;
         busy_q     <= busy_d;
         id_q       <= id_d;
      end
   end

   assign o_tone     = tone_q;
   assign o_busy     = busy_q;
   assign o_sound_id = id_q;

endmodule

// File: tb/tb_pong_sound_ctrl.sv
// Directed testbench for pong_sound_ctrl with small timing parameters.
// Expected tone/busy/id sequences are derived by hand from the sound table.
module tb_pong_sound_ctrl;

   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic       i_enable;
   logic       i_wall_hit;
   logic       i_paddle_hit;
   logic       i_score;
   logic       o_tone;
   logic       o_busy;
   logic [1:0] o_sound_id;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   pong_sound_ctrl #(
      .TICK_DIV(10), .WALL_HALF(8), .PADDLE_HALF(4), .SCORE_HALF(2),
      .WALL_MS(2), .PADDLE_MS(4), .SCORE_MS(5), .GAP_MS(1)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .i_enable    (i_enable),
      .i_wall_hit  (i_wall_hit),
      .i_paddle_hit(i_paddle_hit),
      .i_score     (i_score),
      .o_tone      (o_tone),
      .o_busy      (o_busy),
      .o_sound_id  (o_sound_id)
   );

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic tick();
      @(negedge clk_100MHz);
   endtask

   task automatic applyStimulus(input logic [2:0] reqMask);
      {i_score, i_paddle_hit, i_wall_hit} = reqMask;
   endtask

   task automatic checkOutput(input string tag, input logic expBusy, input logic [1:0] expId,
                              input logic expTone);
      logic [3:0] obs;
      logic [3:0] exp;
      obs = {o_busy, o_sound_id, o_tone};
      exp = {expBusy, expId, expTone};
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: busy/id/tone observed=%b required=%b", tag, obs, exp);
      end
   endtask

   // One-cycle request pulse; leaves the bench on the negedge right after the grant edge.
   task automatic requestAndGrant(input string tag, input logic [2:0] reqMask);
      applyStimulus(reqMask);
      tick();
      applyStimulus(3'b000);
      checkOutput({tag, "_latency"}, 1'b0, 2'd0, 1'b0);
      tick();
   endtask

   // Tone is low for the first half-period after the grant, then alternates every half-period.
   task automatic checkPlay(input string tag, input logic [1:0] id, input int half, input int k0,
                            input int k1, input int pulseAt, input logic [2:0] pulseMask);
      for (int k = k0; k < k1; k++) begin
         checkOutput(tag, 1'b1, id, ((k / half) % 2) == 1);
         applyStimulus((k == pulseAt) ? pulseMask : 3'b000);
         tick();
      end
   endtask

   task automatic checkGapIdle(input string tag);
      for (int k = 0; k < 10; k++) begin
         checkOutput({tag, "_gap"}, 1'b1, 2'd0, 1'b0);
         tick();
      end
      checkOutput({tag, "_idle"}, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic runSound(input string tag, input logic [1:0] id, input int half, input int ms);
      checkPlay(tag, id, half, 0, ms * 10, -1, 3'b000);
      checkGapIdle(tag);
   endtask

   initial begin
      reset    = 1'b0;
      i_enable = 1'b1;
      applyStimulus(3'b000);
      #2 reset = 1'b1;
      #1 checkOutput("reset_state", 1'b0, 2'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      checkOutput("after_reset", 1'b0, 2'd0, 1'b0);

      // Single paddle sound: 40 cycles of tone, 10 cycles of gap.
      requestAndGrant("paddle", 3'b010);
      runSound("paddle", 2'd2, 4, 4);

      // Simultaneous requests drain in priority order.
      tick();
      requestAndGrant("all3", 3'b111);
      runSound("all3_score", 2'd3, 2, 5);
      tick();
      runSound("all3_paddle", 2'd2, 4, 4);
      tick();
      runSound("all3_wall", 2'd1, 8, 2);
      tick();
      checkOutput("all3_drained", 1'b0, 2'd0, 1'b0);

      // Three wall pulses during paddle play coalesce into a single wall sound.
      tick();
      requestAndGrant("coalesce", 3'b010);
      checkPlay("coalesce_paddle", 2'd2, 4, 0, 10, 3, 3'b001);
      checkPlay("coalesce_paddle", 2'd2, 4, 10, 20, 12, 3'b001);
      checkPlay("coalesce_paddle", 2'd2, 4, 20, 40, 25, 3'b001);
      checkGapIdle("coalesce_paddle");
      tick();
      runSound("coalesce_wall", 2'd1, 8, 2);
      tick();
      checkOutput("coalesce_once", 1'b0, 2'd0, 1'b0);
      tick();
      checkOutput("coalesce_once2", 1'b0, 2'd0, 1'b0);

`ifndef SOUND_PREEMPT_EN
      // Score arriving mid-paddle waits for paddle play and gap.
      tick();
      requestAndGrant("nopre", 3'b010);
      checkPlay("nopre_paddle", 2'd2, 4, 0, 40, 12, 3'b100);
      checkGapIdle("nopre_paddle");
      tick();
      runSound("nopre_score", 2'd3, 2, 5);
      tick();
      checkOutput("nopre_drained", 1'b0, 2'd0, 1'b0);
`else
      // Score arriving mid-paddle takes over two cycles later with no gap; paddle is dropped.
      tick();
      requestAndGrant("pre", 3'b010);
      checkPlay("pre_paddle", 2'd2, 4, 0, 8, 6, 3'b100);
      runSound("pre_score", 2'd3, 2, 5);
      for (int k = 0; k < 20; k++) begin
         tick();
         checkOutput("pre_no_resume", 1'b0, 2'd0, 1'b0);
      end
`endif

      // Dropping enable mid-play mutes at the next edge and flushes pending requests.
      tick();
      requestAndGrant("enable", 3'b010);
      checkPlay("enable_paddle", 2'd2, 4, 0, 6, 4, 3'b001);
      i_enable = 1'b0;
      applyStimulus(3'b100);
      tick();
      applyStimulus(3'b000);
      checkOutput("enable_mute", 1'b0, 2'd0, 1'b0);
      i_enable = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         checkOutput("enable_flushed", 1'b0, 2'd0, 1'b0);
      end

      // Asynchronous reset between clock edges clears outputs immediately.
      requestAndGrant("rst", 3'b010);
      checkPlay("rst_paddle", 2'd2, 4, 0, 6, -1, 3'b000);
      checkOutput("rst_before", 1'b1, 2'd2, 1'b1);
      #2 reset = 1'b1;
      #1 checkOutput("rst_async", 1'b0, 2'd0, 1'b0);
      tick();
      reset = 1'b0;
      requestAndGrant("rst_fresh", 3'b001);
      runSound("rst_fresh_wall", 2'd1, 8, 2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pong_sound_ctrl.md
Name: pong_sound_ctrl

Overview:
- Sound scheduler for the Pong game. Accepts one-cycle event requests (wall hit, paddle hit, score) and arbitrates them by fixed priority.
- Drives a single shared square-wave tone generator, which is a programmable clock divider. For each granted sound it sets the half-period and the duration, and it enforces a silent gap between sounds.
- Sits between the game-logic FSM and the speaker/buzzer pin.

Parameters:
- TICK_DIV, 100_000, clk cycles per 1 ms duration tick.
- WALL_HALF, 200_000, tone half-period in cycles for wall sound (250 Hz).
- PADDLE_HALF, 100_000, half-period for paddle sound (500 Hz).
- SCORE_HALF, 50_000, half-period for score sound (1 kHz).
- WALL_MS, 30, wall sound duration in ticks.
- PADDLE_MS, 50, paddle sound duration in ticks.
- SCORE_MS, 300, score sound duration in ticks.
- GAP_MS, 10, silent gap after each sound, in ticks.
- All parameters are ≥1. Counter widths are derived with $clog2.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_enable  in  1  sound enable; low = mute and flush
- i_wall_hit  in  1  request pulse, wall sound
- i_paddle_hit  in  1  request pulse, paddle sound
- i_score  in  1  request pulse, score sound
- o_tone  out  1  square-wave output to speaker
- o_busy  out  1  high in PLAY or GAP
- o_sound_id  out  2  0 = none, 1 = wall, 2 = paddle, 3 = score; nonzero only in PLAY

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - state = IDLE.
  - All pending flags, counters, o_tone, o_busy and o_sound_id are 0.
- Pending flags (one per source):
  - A flag is set at the clock edge where its input is high and i_enable = 1.
  - A flag is cleared when its source is granted.
  - If set and clear hit the same edge, set wins; the sound replays later.
  - Repeated requests while a flag is already pending coalesce into one.
- Priority: score > paddle > wall.
- State IDLE:
  - If any flag is pending, grant the highest-priority one: clear its flag, load its half-period and duration, zero the tick prescaler, tone counter and o_tone, then go to PLAY.
  - Latency: a request pulse at edge k sets the flag; the grant happens at edge k+1. o_busy and o_sound_id are therefore valid 2 cycles after the request cycle.
- State PLAY:
  - The tone counter counts 0..HALF-1; o_tone toggles at HALF-1, so the tone period is 2*HALF cycles and the first toggle comes HALF cycles after the grant.
  - The prescaler wraps every TICK_DIV cycles; each wrap increments the tick count.
  - When the tick count reaches MS, the state goes to GAP at that edge and o_tone is forced to 0. PLAY therefore lasts exactly MS*TICK_DIV cycles.
- State GAP:
  - o_tone = 0, o_sound_id = 0, o_busy = 1.
  - After GAP_MS*TICK_DIV cycles, go to IDLE. IDLE may grant on the following edge.
- Requests arriving in PLAY or GAP stay pending and are served in priority order afterwards. A lower-priority sound waits behind a higher one.
- i_enable = 0, from any state:
  - At the next edge: state = IDLE, all flags cleared, o_tone = 0.
  - No new flags are set while i_enable is low.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SOUND_PREEMPT_EN.
- Defined: in PLAY, if a flag of strictly higher priority than the current sound is pending, it is granted at the next edge (PLAY→PLAY):
  - the new sound's counters are reloaded and o_tone restarts at 0;
  - no gap is inserted;
  - the preempted sound is dropped, not re-queued.
- Undefined: no preemption. Higher-priority requests wait for the current PLAY and GAP to finish.

Test Plan:
Parameter overrides for all tests: TICK_DIV=10, WALL_HALF=8, PADDLE_HALF=4, SCORE_HALF=2, WALL_MS=2, PADDLE_MS=4, SCORE_MS=5, GAP_MS=1.
- Single paddle request: i_paddle_hit pulsed at cycle c →
  - o_busy = 1 and o_sound_id = 2 from c+2;
  - o_tone toggles every 4 cycles, 5 full periods in 40 cycles;
  - then o_sound_id = 0 and o_tone = 0 for 10 cycles;
  - o_busy = 0 at c+52.
- All three requests pulsed in the same cycle → sounds play in order id 3 (50 cycles), id 2 (40), id 1 (20), each followed by a 10-cycle gap; no request is lost.
- Preemption off: i_score pulsed mid-paddle PLAY → paddle completes its 40 cycles and gap, then id 3 plays. Request coalescing: i_wall_hit pulsed 3 times during PLAY → wall plays exactly once.
- i_enable dropped mid-PLAY → next edge o_tone = 0, o_busy = 0, o_sound_id = 0; previously pending requests never play.
- reset asserted mid-PLAY between clock edges → o_tone, o_busy and o_sound_id go to 0 immediately. After release, a fresh request follows the 2-cycle grant latency.
- SOUND_PREEMPT_EN defined: i_score pulsed during paddle PLAY → o_sound_id = 3 two cycles later, o_tone restarts at 0, no gap; the paddle sound never resumes.
